// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file definitions used by the issue scoreboard.
// Entry layout is the tag kept per in-flight instruction.
package regfile_pkg;

    localparam int NUM_REGS      = 16;
    localparam int REG_ADDR_W    = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/flush bundle between the pipeline control and the scoreboard.
// Master drives requests; slave (the scoreboard) answers with status.
interface reg_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
);

    logic                  issue_valid;
    logic                  issue_wb_en;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic [REG_ADDR_W-1:0] issue_src1;
    logic [REG_ADDR_W-1:0] issue_src2;
    logic                  issue_use_src2;
    logic                  issue_stall;
    logic                  retire_valid;
    logic                  flush;
    logic [CNT_W-1:0]      flush_count;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [CNT_W-1:0]      occupancy;
    logic                  full;
    logic                  empty;
    logic                  underflow_err;

    modport master (
        output issue_valid, issue_wb_en, issue_dest,
        output issue_src1, issue_src2, issue_use_src2,
        output retire_valid, flush, flush_count,
        input  issue_stall, pending_mask, occupancy,
        input  full, empty, underflow_err
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest,
        input  issue_src1, issue_src2, issue_use_src2,
        input  retire_valid, flush, flush_count,
        output issue_stall, pending_mask, occupancy,
        output full, empty, underflow_err
    );

endinterface

// File: rtl/reg_scoreboard_match.sv
// Compares one source register against all live writer entries.
// The head can be masked off when it retires (and writes back) this cycle.
module sb_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t             ent [DEPTH],
    input  logic [DEPTH-1:0]      vld,
    input  logic [PW-1:0]         head,
    input  logic                  excl_head,
    input  logic [REG_ADDR_W-1:0] src,
    output logic                  hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent[i].wb_en && ent[i].dest == src &&
                !(excl_head && PW'(i) == head))
                hit = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order scoreboard: ordered queue of destination tags from ID to WB.
// Stalls ID on RAW hazards against older in-flight writers.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic       clk,
    input logic       rst,
    reg_scoreboard_if.slave sb
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t        ent [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CNT_W-1:0] count;
    logic             uf;

    logic [DEPTH-1:0] vld;
    logic             hit1;
    logic             hit2;
    logic             hazard;
    logic             stall;
    logic             accept;
    logic             do_pop;
    logic [CNT_W-1:0] cnt_pop;
    logic [CNT_W-1:0] kill;
    logic [NUM_REGS-1:0] mask;

    // Validity follows from the ring distance to head, so no per-entry flags.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            vld[i] = {1'b0, PW'(i) - head} < count;
    end

    sb_match #(.DEPTH(DEPTH), .PW(PW)) u_m1 (
        .ent       (ent),
        .vld       (vld),
        .head      (head),
        .excl_head (sb.retire_valid),
        .src       (sb.issue_src1),
        .hit       (hit1)
    );

    sb_match #(.DEPTH(DEPTH), .PW(PW)) u_m2 (
        .ent       (ent),
        .vld       (vld),
        .head      (head),
        .excl_head (sb.retire_valid),
        .src       (sb.issue_src2),
        .hit       (hit2)
    );

    assign hazard = sb.issue_valid &
                    (hit1 | (sb.issue_use_src2 & hit2));
    assign stall  = sb.issue_valid &
                    (hazard | (sb.full & ~sb.retire_valid) | sb.flush);
    assign accept = sb.issue_valid & ~stall;

    assign do_pop  = sb.retire_valid & (count != '0);
    assign cnt_pop = count - CNT_W'(do_pop);

    always_comb begin
        kill = '0;
        if (sb.flush)
            kill = (sb.flush_count < cnt_pop) ? sb.flush_count : cnt_pop;
    end

    // Order within one edge: pop, then flush, then push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            uf    <= 1'b0;
        end else begin
            head  <= head + PW'(do_pop);
            tail  <= tail - kill[PW-1:0] + PW'(accept);
            count <= cnt_pop - kill + CNT_W'(accept);
            if (sb.retire_valid && count == '0)
                uf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            ent[tail] <= '{wb_en: sb.issue_wb_en, dest: sb.issue_dest};
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent[i].wb_en)
                mask[ent[i].dest] = 1'b1;
        end
    end

    assign sb.issue_stall   = stall;
    assign sb.pending_mask  = mask;
    assign sb.occupancy     = count;
    assign sb.full          = count == CNT_W'(DEPTH);
    assign sb.empty         = count == '0;
    assign sb.underflow_err = uf;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus random stimulus for reg_scoreboard against a queue model.
// Model keeps in-flight instructions oldest-first in a SV queue.
module tb_reg_scoreboard;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) sb ();

    reg_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    typedef struct {
        bit wb;
        int dest;
    } m_ent_t;

    m_ent_t q[$];
    bit     m_uf;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_match(input int s, input bit rv);
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 && rv) continue;
            if (q[i].wb && q[i].dest == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m = '0;
        foreach (q[i]) if (q[i].wb) m[q[i].dest] = 1'b1;
        return m;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".occ"}, 32'(sb.occupancy), 32'(q.size()));
        chk({tag, ".full"}, 32'(sb.full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(sb.empty), 32'(q.size() == 0));
        chk({tag, ".mask"}, 32'(sb.pending_mask), 32'(m_mask()));
        chk({tag, ".uf"}, 32'(sb.underflow_err), 32'(m_uf));
    endtask

    task automatic step(input bit iv, input bit wb, input int d,
                        input int s1, input int s2, input bit u2,
                        input bit rv, input bit fl, input int fc);
        bit exp_stall;
        bit haz;
        int k;
        @(negedge clk);
        sb.issue_valid    = iv;
        sb.issue_wb_en    = wb;
        sb.issue_dest     = 4'(d);
        sb.issue_src1     = 4'(s1);
        sb.issue_src2     = 4'(s2);
        sb.issue_use_src2 = u2;
        sb.retire_valid   = rv;
        sb.flush          = fl;
        sb.flush_count    = CNT_W'(fc);
        #1;
        check_state("st");
        haz = iv && (m_match(s1, rv) || (u2 && m_match(s2, rv)));
        exp_stall = iv && (haz || (q.size() == DEPTH && !rv) || fl);
        chk("stall", 32'(sb.issue_stall), 32'(exp_stall));
        @(posedge clk);
        if (rv) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_uf = 1'b1;
        end
        if (fl) begin
            k = (fc < q.size()) ? fc : q.size();
            repeat (k) void'(q.pop_back());
        end
        if (iv && !exp_stall) q.push_back('{wb: wb, dest: d});
    endtask

    task automatic idle_retire();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic push_w(input int d);
        step(1, 1, d, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        sb.issue_valid = 0; sb.issue_wb_en = 0; sb.issue_dest = 0;
        sb.issue_src1 = 0; sb.issue_src2 = 0; sb.issue_use_src2 = 0;
        sb.retire_valid = 0; sb.flush = 0; sb.flush_count = 0;
        m_uf = 0;
        #12;
        check_state("reset");
        chk("reset.stall", 32'(sb.issue_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAW on R3, then resolved by same-cycle retire
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        #1 chk("tp1.mask", 32'(sb.pending_mask), 32'h0008);
        step(1, 1, 6, 3, 0, 0, 0, 0, 0);
        step(1, 0, 6, 3, 0, 0, 1, 0, 0);
        #1 chk("tp1.mask_after", 32'(sb.pending_mask), 32'h0000);
        while (q.size() > 0) idle_retire();

        // fill, stall when full, accept with retire and wrap
        push_w(1); push_w(2); push_w(4); push_w(5);
        #1 chk("tp2.full", 32'(sb.full), 32'd1);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 1, 0, 0);
        #1 chk("tp2.occ", 32'(sb.occupancy), 32'd4);
        step(1, 1, 10, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) idle_retire();

        // flush two youngest with a colliding issue
        push_w(7); push_w(8); push_w(9);
        step(1, 1, 11, 0, 0, 0, 0, 1, 2);
        #1 chk("tp3.mask", 32'(sb.pending_mask), 32'h0080);

        // oversized flush plus retire
        push_w(12); push_w(13);
        step(0, 0, 0, 0, 0, 0, 1, 1, 6);
        #1 chk("tp4.empty", 32'(sb.empty), 32'd1);
        push_w(14);
        step(1, 1, 1, 14, 0, 0, 1, 0, 0);

        // duplicate writers to R2; unused src2
        while (q.size() > 0) idle_retire();
        push_w(2); push_w(2);
        idle_retire();
        #1 chk("tp5.mask", 32'(sb.pending_mask), 32'h0004);
        idle_retire();
        push_w(2);
        step(1, 1, 5, 0, 2, 0, 0, 0, 0);
        step(1, 1, 5, 0, 2, 1, 0, 0, 0);
        while (q.size() > 0) idle_retire();

        // underflow and asynchronous reset mid-cycle
        idle_retire();
        #1 chk("tp6.uf", 32'(sb.underflow_err), 32'd1);
        push_w(3); push_w(4); push_w(5);
        @(negedge clk);
        sb.issue_valid = 0; sb.retire_valid = 0; sb.flush = 0;
        #2 rst = 1'b1;
        q.delete();
        m_uf = 0;
        #1 check_state("async");
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7));
        end
        #1 check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
In-order scoreboard that sits beside the 16x32 register file and decides when the decode stage may issue.
- Tracks every instruction issued from ID until it retires at WB, held in a small ordered queue of destination tags.
- Stalls ID on a RAW hazard, meaning a source register that is the pending destination of an older in-flight instruction.
- Supports a branch-flush of the youngest entries.

Parameters:
DEPTH, 4, maximum in-flight instructions between ID and WB; power of two, at least 2.
CNT_W, $clog2(DEPTH)+1, width of occupancy and flush count.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
issue_valid  in  1  ID presents an instruction.
issue_wb_en  in  1  instruction writes a register.
issue_dest  in  4  destination register.
issue_src1  in  4  first source register.
issue_src2  in  4  second source register.
issue_use_src2  in  1  src2 is actually read.
issue_stall  out  1  ID must hold; instruction not accepted.
retire_valid  in  1  oldest in-flight instruction leaves WB this cycle.
flush  in  1  kill youngest entries.
flush_count  in  CNT_W  number of youngest entries to kill.
pending_mask  out  16  bit r set if any valid entry with wb_en targets r.
occupancy  out  CNT_W  valid entries.
full  out  1  occupancy == DEPTH.
empty  out  1  occupancy == 0.
underflow_err  out  1  sticky; retire_valid seen while empty.

Behaviour:
Storage and reset:
- Circular queue of DEPTH entries {wb_en, dest}; head = oldest, tail = next free; pointers wrap modulo DEPTH.
- Reset: pointers 0, occupancy 0, underflow_err 0, all entries invalid. Consequently pending_mask=0, full=0, empty=1, issue_stall=0.
- Reset mid-operation discards all entries immediately (asynchronous).

Hazard and stall (combinational from state plus inputs):
- hazard = issue_valid & (match(src1) | (issue_use_src2 & match(src2))).
- match(s) is true if any valid entry with wb_en has dest==s, excluding the head entry when retire_valid=1 that cycle. The register file writes on negedge, so ID reads the new value the same cycle.
- issue_stall = issue_valid & (hazard | (full & ~retire_valid) | flush).
- accept = issue_valid & ~issue_stall. On accept, push {issue_wb_en, issue_dest} at tail at the next posedge.
- Issue with issue_wb_en=0 still occupies an entry, since every instruction retires.

Retire:
- retire_valid & ~empty: pop head.
- retire_valid & empty: no state change; underflow_err set and held until rst.

Flush:
- Removes k = min(flush_count, occupancy after this cycle's retire) youngest entries; tail moves back by k, modulo DEPTH.
- flush_count=0 is a no-op. Flush always blocks issue in the same cycle.

Simultaneous events, applied in this order within one posedge: retire pop, then flush, then push. Push cannot coincide with flush.
- Full + retire + issue: accepted; occupancy stays DEPTH.
- Self-dependence is not a hazard: issue_dest equal to its own src is checked only against older entries.

Registered outputs update on posedge. pending_mask, full, empty and occupancy are derived from registered state only.

Decomposition:
Shared package regfile_pkg holds:
- NUM_REGS=16, REG_ADDR_W=4.
- Entry struct/typedef {wb_en, dest}.
- Default DEPTH.

One natural sub-module: sb_match, a combinational comparator of one source against all valid entries, with a head-exclude input. It is instantiated twice (src1, src2).

Test Plan:
- Reset then issue {wb_en=1, dest=R3}; next cycle issue src1=R3 -> issue_stall=1, pending_mask=0x0008. retire_valid -> same cycle issue_stall=0; instruction accepted; pending_mask=0x0000 after the edge.
- Issue 4 non-conflicting writes (R1,R2,R4,R5) -> full=1, occupancy=4. Fifth issue -> stall. Fifth issue with retire_valid the same cycle -> accepted; occupancy stays 4; head advances and pointers wrap.
- In-flight R7,R8,R9 and flush with flush_count=2 -> occupancy=1, pending_mask=0x0080. Simultaneous issue rejected (stall=1).
- flush_count=6 with occupancy 3 plus retire -> occupancy 0, empty=1, pointers consistent; subsequent issue/retire works.
- Two in-flight writes to R2; retire one -> pending_mask bit2 stays 1. Retire second -> 0. issue_use_src2=0 with src2=R2 -> no stall.
- retire_valid while empty -> underflow_err=1, occupancy stays 0. Async rst mid-cycle with 3 entries -> all outputs at reset values before the next edge.
